insn_fetch: RTL and testbench
=============================

# insn_fetch

Instruction prefetch stage between a variable-latency instruction memory and the core's instruction port. It runs ahead of the core's fetch address and fetches sequential words into a small queue. It presents the head word to the core when the head's address matches the address the core is requesting. A mismatch is a taken jump or reset: the queue is flushed and fetching restarts at the core's address.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- RESET_VECTOR, 32'h0000_1000, first address fetched after reset
- clk  in  1  clock; all state updates on rising edge
- _reset  in  1  asynchronous, active-low reset
- core_req  in  1  core wants an instruction this cycle
- core_addr  in  32  word address the core wants; stable while core_req is high
- core_ready  out  1  core_data is valid for core_addr this cycle
- core_data  out  32  instruction word at queue head
- mem_req  out  1  request to instruction memory
- mem_addr  out  32  word address of request; stable while mem_req is high
- mem_ack  in  1  memory completes request; may assert in the first cycle of mem_req
- mem_data  in  32  read data, valid only when mem_ack is high

## Operation
- Queue entry holds {addr[31:0], data[31:0]}. Head is valid when count != 0.
- hit = core_req & (count != 0) & (head.addr == core_addr). core_ready = hit, combinational. core_data = head.data when count != 0, else 0.
- On hit, the head is popped at the rising edge.
- miss = core_req & !hit. On miss:
  - the queue is flushed (count := 0) at the edge;
  - fetch_ptr := core_addr.
- Memory handshake:
  - one request outstanding at most;
  - mem_req/mem_addr are held until the cycle in which mem_ack = 1;
  - mem_req drops or re-launches on the following edge.
- FSM states:
  - IDLE: no request outstanding. Issue when count < DEPTH and no miss this cycle → BUSY, mem_addr := fetch_ptr. On miss, launch from core_addr on the next edge.
  - BUSY: on mem_ack without miss, push {mem_addr, mem_data} and fetch_ptr := fetch_ptr + 1, modulo 2^32. Then:
    - if room remains after the push/pop accounting, stay BUSY with mem_addr := fetch_ptr + 1;
    - otherwise go to IDLE.
  - BUSY on miss: if mem_ack = 1 in the same cycle, discard the data and relaunch at core_addr. If mem_ack = 0, go to DROP.
  - DROP: the outstanding response is discarded on mem_ack, then launch at fetch_ptr → BUSY. A further miss in DROP only updates fetch_ptr.
- Room test counts the outstanding request: issue only if count + (state == BUSY) < DEPTH after this edge's pop.
- Pop and push in the same edge: count unchanged; full queue stays full.
- Address wrap: 32'hFFFF_FFFF is followed by 32'h0000_0000; no special case.
- No instruction decoding. Data is passed through unmodified, including all-ones (illegal) words.

## Timing
- Reset (asynchronous): count = 0, state = IDLE, fetch_ptr = RESET_VECTOR. Outputs:
  - mem_req = 0;
  - mem_addr = RESET_VECTOR;
  - core_ready = 0;
  - core_data = 0.
- Reset mid-request: mem_req drops immediately. The memory must abandon the request on the same reset. A mem_ack during reset is ignored.
- First edge after reset release: mem_req = 1, mem_addr = RESET_VECTOR.
- Miss-to-ready with a zero-wait memory (ack in the first cycle):
  - edge 0: flush;
  - edge 1: push;
  - core_ready high after edge 1, i.e. 2 cycles.
- With L wait cycles, miss-to-ready is 2 + L cycles.
- Steady sequential stream with zero-wait memory: one word per cycle, one hit per cycle after fill.

## Structure
- Shared package tenyr_pkg holds:
  - WORD_W = 32;
  - RESET_VECTOR default;
  - fetch FSM enum {IDLE, BUSY, DROP}.
- One sub-module, fetch_fifo: DEPTH-entry {addr, data} queue with push, pop, flush, count, head outputs; asynchronous reset.
- insn_fetch contains the FSM, fetch_ptr, hit compare and the fifo instance.

## Test plan
- Reset, zero-wait memory returning data = addr ^ 32'hA5A5_A5A5, core_req high with core_addr stepping from 32'h1000:
  - mem_addr = 32'h1000 after the first edge;
  - core_ready after edge 2;
  - then one word per cycle with correct data.
- Core stalls (core_req = 0) with 3-wait-cycle memory:
  - queue fills to DEPTH = 4, mem_req drops, fetched addresses 32'h1000–32'h1003;
  - resuming gives 4 back-to-back hits.
- Jump: core_addr changes from 32'h1002 to 32'h2000 while a request for 32'h1005 is outstanding (BUSY, no ack):
  - DROP entered; the 32'h1005 response is discarded;
  - next mem_addr = 32'h2000; core_ready only when head.addr = 32'h2000.
- Miss in the same cycle as mem_ack: the acked data is discarded and mem_addr = core_addr on the next edge.
- Wrap: core_addr = 32'hFFFF_FFFE, sequential fetch → mem_addr sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, all delivered.
- _reset asserted mid-BUSY and mid-DROP:
  - mem_req = 0 and core_ready = 0 immediately;
  - after release, the fetch restarts at RESET_VECTOR with an empty queue.

Source files
------------

// File: rtl/tenyr_pkg.sv
// Shared types and constants for the tenyr instruction fetch path.
// Holds the word width, default reset vector and fetch FSM states.
package tenyr_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_RESET_VECTOR = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {addr, data} entries.
// Flush wins over push/pop; push and pop together keep the count.
module fetch_fifo
  import tenyr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         _reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_ptr];

endmodule

// File: rtl/insn_fetch.sv
// Sequential instruction prefetcher between imem and the core.
// Runs ahead of core_addr; any unexpected core address flushes and restarts.
module insn_fetch
  import tenyr_pkg::*;
#(
  parameter int                DEPTH        = 4,
  parameter logic [WORD_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              core_req,
  input  logic [WORD_W-1:0] core_addr,
  output logic              core_ready,
  output logic [WORD_W-1:0] core_data,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [WORD_W-1:0] fetch_ptr_q;
  logic [WORD_W-1:0] fetch_ptr_d;
  logic [WORD_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_addr_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          valid;
  logic          hit;
  logic          on_path;
  logic          miss;
  logic          push;
  logic [CW:0]   after_pop;
  logic          room_idle;
  logic          room_busy;

  assign valid = count != '0;
  assign hit   = core_req & valid & (head.addr == core_addr);

  // An empty queue already heading for core_addr is not a jump.
  assign on_path = !valid & (core_addr == fetch_ptr_q);
  assign miss    = core_req & !hit & !on_path;

  assign after_pop = {1'b0, count} - {{CW{1'b0}}, hit};
  assign room_idle = after_pop < DEPTH_W;
  assign room_busy = (after_pop + (CW + 1)'(1)) < DEPTH_W;

  assign push_entry = {mem_addr_q, mem_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    ._reset     (_reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (hit),
    .flush      (miss),
    .count      (count),
    .head       (head)
  );

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    mem_addr_d  = mem_addr_q;
    push        = 1'b0;
    if (miss) begin
      fetch_ptr_d = core_addr;
    end
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          state_d    = BUSY;
          mem_addr_d = core_addr;
        end else if (room_idle) begin
          state_d    = BUSY;
          mem_addr_d = fetch_ptr_q;
        end
      end
      BUSY: begin
        unique case (1'b1)
          mem_ack && miss: begin
            mem_addr_d = core_addr;
          end
          mem_ack && !miss: begin
            push        = 1'b1;
            fetch_ptr_d = fetch_ptr_q + WORD_W'(1);
            if (room_busy) begin
              mem_addr_d = fetch_ptr_q + WORD_W'(1);
            end else begin
              state_d = IDLE;
            end
          end
          !mem_ack && miss: begin
            state_d = DROP;
          end
          default: begin
            state_d = BUSY;
          end
        endcase
      end
      DROP: begin
        if (mem_ack) begin
          state_d    = BUSY;
          mem_addr_d = miss ? core_addr : fetch_ptr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      fetch_ptr_q <= RESET_VECTOR;
      mem_addr_q  <= RESET_VECTOR;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign mem_req    = state_q != IDLE;
  assign mem_addr   = mem_addr_q;
  assign core_ready = hit;
  assign core_data  = valid ? head.data : '0;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: per-cycle vector tables plus
// hand-written fill, reset-abort and ignored-ack sequences.
module tb_insn_fetch;

  logic        clk;
  logic        _reset;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_ready;
  logic [31:0] core_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  logic        mem_hold;
  logic        force_ack;
  int unsigned mem_lat;
  int unsigned wcnt;

  int nvec;
  int nfail;

  logic [31:0] acked[$];

  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] MEM = 4'b0011;
  localparam logic [3:0] RD  = 4'b1100;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        hld;
    logic [3:0]  care;
    logic        rdy;
    logic [31:0] dat;
    logic        mrq;
    logic [31:0] mad;
  } vec_t;

  vec_t vq[$];

  insn_fetch #(
    .DEPTH        (4),
    .RESET_VECTOR (32'h0000_1000)
  ) dut (
    .clk        (clk),
    ._reset     (_reset),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_ready (core_ready),
    .core_data  (core_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after mem_lat wait cycles, data = addr ^ A5A5A5A5.
  always @(posedge clk or negedge _reset) begin
    if (!_reset) wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign mem_ack  = force_ack | (mem_req & !mem_hold & (wcnt >= mem_lat));
  assign mem_data = mem_ack ? (mem_addr ^ 32'hA5A5_A5A5) : 32'h0;

  always @(posedge clk) begin
    if (_reset && mem_req && mem_ack) acked.push_back(mem_addr);
  end

  function automatic vec_t mk(logic req, logic [31:0] addr, logic hld,
                              logic [3:0] care, logic rdy, logic [31:0] dat,
                              logic mrq, logic [31:0] mad);
    vec_t v;
    v.req  = req;
    v.addr = addr;
    v.hld  = hld;
    v.care = care;
    v.rdy  = rdy;
    v.dat  = dat;
    v.mrq  = mrq;
    v.mad  = mad;
    return v;
  endfunction

  task automatic chk(string nm, vec_t v);
    logic bad;
    bad = 1'b0;
    if (v.care[3] && core_ready !== v.rdy) bad = 1'b1;
    if (v.care[2] && core_data !== v.dat) bad = 1'b1;
    if (v.care[1] && mem_req !== v.mrq) bad = 1'b1;
    if (v.care[0] && mem_addr !== v.mad) bad = 1'b1;
    nvec++;
    if (bad) begin
      nfail++;
      $display("FAIL %s: got ready=%0b data=%h mem_req=%0b mem_addr=%h want ready=%0b data=%h mem_req=%0b mem_addr=%h (care=%b)",
               nm, core_ready, core_data, mem_req, mem_addr,
               v.rdy, v.dat, v.mrq, v.mad, v.care);
    end
  endtask

  task automatic check_val(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(string nm, vec_t v);
    core_req  = v.req;
    core_addr = v.addr;
    mem_hold  = v.hld;
    #2;
    chk(nm, v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(string nm);
    foreach (vq[i]) cyc($sformatf("%s[%0d]", nm, i), vq[i]);
    vq.delete();
  endtask

  task automatic do_reset();
    _reset    = 1'b0;
    core_req  = 1'b0;
    core_addr = 32'h0;
    mem_hold  = 1'b0;
    force_ack = 1'b0;
    mem_lat   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", mk(0, 0, 0, ALL, 0, 32'h0, 0, 32'h1000));
    _reset = 1'b1;
  endtask

  // Assert reset mid-cycle with a stray ack, then release after an edge.
  task automatic abort_reset(string nm);
    _reset = 1'b0;
    #1;
    chk({nm, "_immediate"}, mk(core_req, core_addr, 0, ALL, 0, 32'h0, 0, 32'h1000));
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    mem_hold  = 1'b0;
    _reset    = 1'b1;
    cyc({nm, "_c0"}, mk(1, 32'h1000, 0, ALL, 0, 32'h0, 0, 32'h1000));
    cyc({nm, "_c1"}, mk(1, 32'h1000, 0, ALL, 0, 32'h0, 1, 32'h1000));
    cyc({nm, "_c2"}, mk(1, 32'h1000, 0, ALL, 1, 32'hA5A5_B5A5, 1, 32'h1001));
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    _reset    = 1'b0;
    core_req  = 1'b0;
    core_addr = 32'h0;
    mem_hold  = 1'b0;
    force_ack = 1'b0;
    mem_lat   = 0;

    // Zero-wait stream from reset.
    do_reset();
    vq.push_back(mk(1, 32'h1000, 0, ALL, 0, 32'h0,         0, 32'h1000));
    vq.push_back(mk(1, 32'h1000, 0, ALL, 0, 32'h0,         1, 32'h1000));
    vq.push_back(mk(1, 32'h1000, 0, ALL, 1, 32'hA5A5_B5A5, 1, 32'h1001));
    vq.push_back(mk(1, 32'h1001, 0, ALL, 1, 32'hA5A5_B5A4, 1, 32'h1002));
    vq.push_back(mk(1, 32'h1002, 0, ALL, 1, 32'hA5A5_B5A7, 1, 32'h1003));
    vq.push_back(mk(1, 32'h1003, 0, ALL, 1, 32'hA5A5_B5A6, 1, 32'h1004));
    vq.push_back(mk(1, 32'h1004, 0, ALL, 1, 32'hA5A5_B5A1, 1, 32'h1005));
    run_table("stream");

    // Stall with 3-wait memory: queue fills then mem_req drops.
    do_reset();
    mem_lat = 3;
    acked.delete();
    for (int i = 0; i < 60 && !(acked.size() == 4 && !mem_req); i++) begin
      @(posedge clk);
      #1;
    end
    check_val("fill_count", 32'(acked.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("fill_addr%0d", i),
                (i < acked.size()) ? acked[i] : 32'h0, 32'h1000 + 32'(i));
    end
    cyc("stall0", mk(0, 32'h0, 0, MEM, 0, 32'h0, 0, 32'h1003));
    cyc("stall1", mk(0, 32'h0, 0, MEM, 0, 32'h0, 0, 32'h1003));
    cyc("resume0", mk(1, 32'h1000, 0, ALL, 1, 32'hA5A5_B5A5, 0, 32'h1003));
    cyc("resume1", mk(1, 32'h1001, 0, ALL, 1, 32'hA5A5_B5A4, 1, 32'h1004));
    cyc("resume2", mk(1, 32'h1002, 0, ALL, 1, 32'hA5A5_B5A7, 1, 32'h1004));
    cyc("resume3", mk(1, 32'h1003, 0, ALL, 1, 32'hA5A5_B5A6, 1, 32'h1004));

    // Jump during an outstanding request, miss with ack, address wrap.
    do_reset();
    vq.push_back(mk(0, 32'h1000, 0, ALL, 0, 32'h0,         0, 32'h1000));
    vq.push_back(mk(0, 32'h1000, 0, ALL, 0, 32'h0,         1, 32'h1000));
    vq.push_back(mk(0, 32'h1000, 0, ALL, 0, 32'hA5A5_B5A5, 1, 32'h1001));
    vq.push_back(mk(0, 32'h1000, 0, ALL, 0, 32'hA5A5_B5A5, 1, 32'h1002));
    vq.push_back(mk(0, 32'h1000, 0, ALL, 0, 32'hA5A5_B5A5, 1, 32'h1003));
    vq.push_back(mk(1, 32'h1000, 0, ALL, 1, 32'hA5A5_B5A5, 0, 32'h1003));
    vq.push_back(mk(1, 32'h1001, 0, ALL, 1, 32'hA5A5_B5A4, 1, 32'h1004));
    vq.push_back(mk(1, 32'h1002, 1, ALL, 1, 32'hA5A5_B5A7, 1, 32'h1005));
    vq.push_back(mk(1, 32'h2000, 1, ALL, 0, 32'hA5A5_B5A6, 1, 32'h1005));
    vq.push_back(mk(1, 32'h2000, 1, ALL, 0, 32'h0,         1, 32'h1005));
    vq.push_back(mk(1, 32'h2000, 0, ALL, 0, 32'h0,         1, 32'h1005));
    vq.push_back(mk(1, 32'h2000, 0, ALL, 0, 32'h0,         1, 32'h2000));
    vq.push_back(mk(1, 32'h2000, 0, ALL, 1, 32'hA5A5_85A5, 1, 32'h2001));
    vq.push_back(mk(1, 32'h3000, 0, ALL, 0, 32'hA5A5_85A4, 1, 32'h2002));
    vq.push_back(mk(1, 32'h3000, 0, ALL, 0, 32'h0,         1, 32'h3000));
    vq.push_back(mk(1, 32'h3000, 0, ALL, 1, 32'hA5A5_95A5, 1, 32'h3001));
    vq.push_back(mk(1, 32'hFFFF_FFFE, 0, ALL, 0, 32'hA5A5_95A4, 1, 32'h3002));
    vq.push_back(mk(1, 32'hFFFF_FFFE, 0, ALL, 0, 32'h0,     1, 32'hFFFF_FFFE));
    vq.push_back(mk(1, 32'hFFFF_FFFE, 0, ALL, 1, 32'h5A5A_5A5B, 1, 32'hFFFF_FFFF));
    vq.push_back(mk(1, 32'hFFFF_FFFF, 0, ALL, 1, 32'h5A5A_5A5A, 1, 32'h0000_0000));
    vq.push_back(mk(1, 32'h0000_0000, 0, ALL, 1, 32'hA5A5_A5A5, 1, 32'h0000_0001));
    vq.push_back(mk(1, 32'h0000_0001, 0, ALL, 1, 32'hA5A5_A5A4, 1, 32'h0000_0002));
    run_table("jump_wrap");

    // Reset while BUSY with a word queued.
    do_reset();
    cyc("rb_c0", mk(0, 32'h0, 0, MEM, 0, 32'h0, 0, 32'h1000));
    cyc("rb_c1", mk(0, 32'h0, 0, MEM, 0, 32'h0, 1, 32'h1000));
    core_req  = 1'b1;
    core_addr = 32'h1000;
    #2;
    chk("rb_c2", mk(1, 32'h1000, 0, ALL, 1, 32'hA5A5_B5A5, 1, 32'h1001));
    abort_reset("rst_busy");

    // Reset while DROP.
    do_reset();
    cyc("rd_c0", mk(0, 32'h0, 1, MEM, 0, 32'h0, 0, 32'h1000));
    cyc("rd_c1", mk(1, 32'h5000, 1, ALL, 0, 32'h0, 1, 32'h1000));
    core_req  = 1'b1;
    core_addr = 32'h5000;
    mem_hold  = 1'b1;
    #2;
    chk("rd_c2", mk(1, 32'h5000, 1, ALL, 0, 32'h0, 1, 32'h1000));
    abort_reset("rst_drop");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
